// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing one 16-bit async SRAM; each 32-bit access runs as LO then HI halfword phases.
// Define SRAM_ARB_FIXED_PRIORITY_EN for fixed A-over-B priority; the default build is round-robin.
`timescale 1ns/1ps

module sram_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_rd,
    input  logic        a_wr,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic [31:0] a_rdata,
    output logic        a_ready,
    input  logic        b_rd,
    input  logic        b_wr,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic [31:0] b_rdata,
    output logic        b_ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   wait_cnt, wait_cnt_d;
    logic            gnt_b, gnt_b_d;
    logic            op_wr, op_wr_d;
    logic [16:0]     word, word_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [15:0]     rd_lo;
    logic [15:0]     dq_out;
    logic            dq_oe;
    logic            a_req, b_req, pick_b, phase_end;
    logic            out_phase, out_hi;
    logic            unused_addr_bits;

    assign a_req     = a_rd | a_wr;
    assign b_req     = b_rd | b_wr;
    assign phase_end = (wait_cnt == CW'(WAIT_CYCLES));
    assign unused_addr_bits = ^{a_addr[31:19], a_addr[1:0], b_addr[31:19], b_addr[1:0]};

`ifdef SRAM_ARB_FIXED_PRIORITY_EN
    assign pick_b = b_req & ~a_req;
`else
    logic last_b;

    // On a tie the port that did not win last time is granted.
    assign pick_b = b_req & (~a_req | ~last_b);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_b <= 1'b1;
        else if (state == IDLE && (a_req | b_req))
            last_b <= pick_b;
    end
`endif

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        gnt_b_d    = gnt_b;
        op_wr_d    = op_wr;
        word_d     = word;
        wdata_d    = wdata_q;
        case (state)
            IDLE: if (a_req | b_req) begin
                gnt_b_d    = pick_b;
                op_wr_d    = pick_b ? b_wr : a_wr;
                word_d     = pick_b ? b_addr[18:2] : a_addr[18:2];
                wdata_d    = pick_b ? b_wdata : a_wdata;
                wait_cnt_d = '0;
                state_d    = LO;
            end
            LO, HI: if (phase_end) begin
                wait_cnt_d = '0;
                state_d    = (state == LO) ? HI : DONE;
            end else begin
                wait_cnt_d = wait_cnt + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            gnt_b    <= 1'b0;
            op_wr    <= 1'b0;
            word     <= '0;
            wdata_q  <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            gnt_b    <= gnt_b_d;
            op_wr    <= op_wr_d;
            word     <= word_d;
            wdata_q  <= wdata_d;
        end
    end

    // Read halves are captured on the last cycle of each phase; the port word updates only at HI's end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_lo   <= '0;
            a_rdata <= '0;
            b_rdata <= '0;
        end else if (phase_end && !op_wr) begin
            if (state == LO)
                rd_lo <= SRAM_DQ;
            else if (state == HI && gnt_b)
                b_rdata <= {SRAM_DQ, rd_lo};
            else if (state == HI)
                a_rdata <= {SRAM_DQ, rd_lo};
        end
    end

    // SRAM pins are registered from the next state so they are stable for a whole phase.
    assign out_phase = (state_d == LO) || (state_d == HI);
    assign out_hi    = (state_d == HI);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            SRAM_ADDR <= '0;
            SRAM_CE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
        end else begin
            SRAM_CE_N <= ~out_phase;
            SRAM_UB_N <= ~out_phase;
            SRAM_LB_N <= ~out_phase;
            SRAM_WE_N <= ~(out_phase & op_wr_d);
            SRAM_OE_N <= ~(out_phase & ~op_wr_d);
            dq_oe     <= out_phase & op_wr_d;
            if (out_phase) begin
                SRAM_ADDR <= {word_d, out_hi};
                dq_out    <= out_hi ? wdata_d[31:16] : wdata_d[15:0];
            end
        end
    end

    assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

    assign a_ready = ~a_req | (state == DONE && !gnt_b);
    assign b_ready = ~b_req | (state == DONE &&  gnt_b);

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: word-level reference memory, halfword SRAM model, directed and random traffic.
`timescale 1ns/1ps

module tb_sram_arbiter;

    localparam int W = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_rd, a_wr, b_rd, b_wr;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ready, b_ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        ub, lb, we, ce, oe;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_a[$];
    exp_t        exp_b[$];
    int          grant_log[$];
    logic [37:0] wr_trace[$];
    logic [31:0] ref_mem[int];
    logic [15:0] mem[0:1023];

    // Power-up SRAM content, with the two halfwords of word 8 preset.
    function automatic logic [15:0] init_hw(int h);
        if (h == 16) return 16'h1234;
        if (h == 17) return 16'hABCD;
        return 16'(h * 37) ^ 16'h5A5A;
    endfunction

    function automatic logic [31:0] ref_read(int w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return {init_hw(2 * w + 1), init_hw(2 * w)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = init_hw(i);
        forever begin
            @(posedge clk);
            if (!ce && !we) mem[sram_addr[9:0]] <= sram_dq;
        end
    end

    assign sram_dq = (!ce && !oe && we) ? mem[sram_addr[9:0]] : 16'hzzzz;

    sram_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .a_rd(a_rd), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata), .a_ready(a_ready),
        .b_rd(b_rd), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata), .b_ready(b_ready),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
        .SRAM_UB_N(ub), .SRAM_LB_N(lb), .SRAM_WE_N(we), .SRAM_CE_N(ce), .SRAM_OE_N(oe)
    );

    // Issue one access on a port starting in a fresh cycle; lat counts cycles until ready is seen.
    task automatic access(input bit port, input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat);
        exp_t e;
        int   w;
        w      = int'(addr[18:2]);
        e.wr   = wr;
        e.data = wr ? 32'h0 : ref_read(w);
        if (wr) ref_mem[w] = wdata;
        if (port == 1'b0) begin
            exp_a.push_back(e);
            a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata;
        end else begin
            exp_b.push_back(e);
            b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wdata;
        end
        for (lat = 0; lat <= 100; lat++) begin
            @(negedge clk);
            if (port ? b_ready : a_ready) break;
        end
        if (lat > 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: port %0d saw no ready within 100 cycles", port);
        end
        @(posedge clk);
        #1;
        if (port == 1'b0) begin a_rd = 1'b0; a_wr = 1'b0; end
        else              begin b_rd = 1'b0; b_wr = 1'b0; end
    endtask

    task automatic rand_port(input bit port);
        int          lat, k, gap;
        logic [31:0] addr;
        for (int n = 0; n < 40; n++) begin
            k          = $urandom_range(0, 2);
            addr       = $urandom;
            addr[18:11] = '0;
            addr[10:2] = 9'(64 * (int'(port) + 1) + $urandom_range(0, 63));
            access(port, k != 1, k != 0, addr, $urandom, lat);
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    // Monitor: every completion pops the port's expectation; also logs write-phase pin values.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if ((a_rd | a_wr) && a_ready) begin
                if (exp_a.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL a_ready_spurious: actual 1 required 0");
                end else begin
                    e = exp_a.pop_front();
                    grant_log.push_back(0);
                    if (!e.wr) check("a_rdata", a_rdata, e.data);
                end
            end
            if ((b_rd | b_wr) && b_ready) begin
                if (exp_b.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL b_ready_spurious: actual 1 required 0");
                end else begin
                    e = exp_b.pop_front();
                    grant_log.push_back(1);
                    if (!e.wr) check("b_rdata", b_rdata, e.data);
                end
            end
            if (!ce) check("sram_addr_upper", sram_addr[17:10], 0);
            if (!we) wr_trace.push_back({ce, ub, lb, oe, sram_addr, sram_dq});
        end
    end

    // Additional instances sweep the wait-state count with single-port traffic.
    for (genvar g = 0; g < 2; g++) begin : g_ws
        localparam int WS = (g == 0) ? 0 : 3;
        logic        rst_g, rd_g, wr_g, ready_g, done_g;
        logic [31:0] addr_g, wdata_g, rdata_g, unused_b_rdata_g;
        logic        unused_b_ready_g, unused_ub_g, unused_lb_g, we_g, ce_g, oe_g;
        logic [17:0] sa_g;
        wire  [15:0] dq_g;
        logic [15:0] mem_g[0:255];

        assign dq_g = (!ce_g && !oe_g && we_g) ? mem_g[sa_g[7:0]] : 16'hzzzz;

        sram_arbiter #(.WAIT_CYCLES(WS)) dut_g (
            .clk(clk), .rst(rst_g),
            .a_rd(rd_g), .a_wr(wr_g), .a_addr(addr_g), .a_wdata(wdata_g), .a_rdata(rdata_g), .a_ready(ready_g),
            .b_rd(1'b0), .b_wr(1'b0), .b_addr(32'h0), .b_wdata(32'h0),
            .b_rdata(unused_b_rdata_g), .b_ready(unused_b_ready_g),
            .SRAM_DQ(dq_g), .SRAM_ADDR(sa_g),
            .SRAM_UB_N(unused_ub_g), .SRAM_LB_N(unused_lb_g), .SRAM_WE_N(we_g), .SRAM_CE_N(ce_g), .SRAM_OE_N(oe_g)
        );

        initial begin
            for (int i = 0; i < 256; i++) mem_g[i] = init_hw(i);
            forever begin
                @(posedge clk);
                if (!ce_g && !we_g) mem_g[sa_g[7:0]] <= dq_g;
            end
        end

        initial begin
            int lat;
            done_g = 1'b0;
            rst_g = 1'b1; rd_g = 1'b0; wr_g = 1'b0; addr_g = '0; wdata_g = '0;
            #2 rst_g = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_g = 1'b1;
            @(posedge clk);
            #1;
            for (int op = 0; op < 3; op++) begin
                rd_g    = (op != 1);
                wr_g    = (op == 1);
                addr_g  = (op == 0) ? 32'h20 : 32'h30;
                wdata_g = 32'h5566_7788;
                for (lat = 0; lat <= 50; lat++) begin
                    @(negedge clk);
                    if (ready_g) break;
                end
                check($sformatf("ws%0d_latency_op%0d", WS, op), lat, 2 * WS + 3);
                if (op != 1)
                    check($sformatf("ws%0d_rdata_op%0d", WS, op), rdata_g,
                          (op == 0) ? 32'hABCD_1234 : 32'h5566_7788);
                @(posedge clk);
                #1;
                rd_g = 1'b0; wr_g = 1'b0;
                @(posedge clk);
                #1;
            end
            done_g = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat, lat2;
        int          exp_order[6];
        logic [37:0] exp_tr;

`ifdef SRAM_ARB_FIXED_PRIORITY_EN
        exp_order = '{0, 0, 0, 1, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1};
`endif
        rst = 1'b1;
        a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
        a_addr = '0; a_wdata = '0; b_addr = '0; b_wdata = '0;
        #2 rst = 1'b0;
        a_rd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl_n", {ub, lb, we, ce, oe}, 5'h1F);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_a_rdata", a_rdata, 0);
        check("rst_b_rdata", b_rdata, 0);
        check("rst_a_ready_requesting", a_ready, 0);
        check("rst_b_ready_idle", b_ready, 1);
        a_rd = 1'b0;
        rst  = 1'b1;
        @(posedge clk);
        #1;

        access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, lat);
        check("single_read_latency", lat, 2 * W + 3);

        wr_trace.delete();
        access(1'b1, 1'b0, 1'b1, 32'h44, 32'hCAFE_BABE, lat);
        check("single_write_latency", lat, 2 * W + 3);
        check("write_trace_len", wr_trace.size(), 2 * (W + 1));
        for (int i = 0; i < 2 * (W + 1) && i < wr_trace.size(); i++) begin
            exp_tr = (i < W + 1) ? {4'b0001, 18'h22, 16'hBABE} : {4'b0001, 18'h23, 16'hCAFE};
            check($sformatf("write_trace_%0d", i), wr_trace[i], exp_tr);
        end
        access(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, lat);

        grant_log.delete();
        fork
            access(1'b0, 1'b1, 1'b0, 32'h24, 32'h0, lat);
            begin
                repeat (2) @(posedge clk);
                #1;
                access(1'b1, 1'b1, 1'b0, 32'h48, 32'h0, lat2);
            end
        join
        check("blocked_a_latency", lat, 2 * W + 3);
        check("blocked_b_latency", lat2, 4 * W + 5);
        check("blocked_order_len", grant_log.size(), 2);
        if (grant_log.size() == 2) check("blocked_order", {grant_log[0][0], grant_log[1][0]}, 2'b01);

        a_wr = 1'b1; a_addr = 32'h400; a_wdata = 32'h1122_3344;
        repeat (3) @(posedge clk);
        #2;
        check("midreset_in_hi_write", {we, sram_addr}, {1'b0, 18'h201});
        rst = 1'b0;
        #1;
        check("midreset_ctrl_n", {ub, lb, we, ce, oe}, 5'h1F);
        check("midreset_sram_addr", sram_addr, 0);
        check("midreset_a_rdata", a_rdata, 0);
        check("midreset_b_rdata", b_rdata, 0);
        check("midreset_a_ready", a_ready, 0);
        @(posedge clk);
        #1;
        a_wr = 1'b0;
        rst  = 1'b1;
        @(posedge clk);
        #1;

        grant_log.delete();
        fork
            repeat (3) access(1'b0, 1'b1, 1'b0, 32'h28, 32'h0, lat);
            repeat (3) access(1'b1, 1'b1, 1'b0, 32'h2C, 32'h0, lat2);
        join
        check("tie_order_len", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check($sformatf("tie_grant_%0d", i), grant_log[i], exp_order[i]);

        fork
            rand_port(1'b0);
            rand_port(1'b1);
        join
        repeat (5) @(posedge clk);
        #1;
        check("exp_a_drained", exp_a.size(), 0);
        check("exp_b_drained", exp_b.size(), 0);
        foreach (ref_mem[w])
            check($sformatf("sram_word_%0h", w), {mem[2 * w + 1], mem[2 * w]}, ref_mem[w]);

        wait (g_ws[0].done_g && g_ws[1].done_g);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
